// File: rtl/cpu_io_if.sv
// cpu_io_if: CPU-side operand handshake and output capture signals
interface cpu_io_if;
  logic       cpu_in_req;
  logic       cpu_out_strobe;
  logic [7:0] cpu_nout;
  logic       cpu_halt;
  logic [7:0] nin;
  logic       enter;
  modport master (output cpu_in_req, cpu_out_strobe, cpu_nout, cpu_halt, input nin, enter);
  modport slave (input cpu_in_req, cpu_out_strobe, cpu_nout, cpu_halt, output nin, enter);
endinterface

// File: rtl/cpu_io_host.sv
// cpu_io_host: operand FIFO feeding a CPU input handshake, plus CPU output capture
module cpu_io_host #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cpu_io_if.slave                cpu,
  input  logic                   push,
  input  logic [7:0]             push_data,
  output logic [7:0]             out_last,
  output logic [7:0]             out_count,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   halted
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, PRESENT, RELEASE, HALTED} state_t;
  state_t state, nxt;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic pop, wr;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign wr = push && (!full || pop);
  always_comb begin
    nxt = state;
    pop = 1'b0;
    case (state)
      IDLE:    nxt = (cpu.cpu_in_req && !empty) ? PRESENT : IDLE;
      PRESENT: begin
        nxt = cpu.cpu_in_req ? PRESENT : RELEASE;
        pop = !cpu.cpu_in_req && !cpu.cpu_halt;
      end
      RELEASE: nxt = IDLE;
      default: nxt = HALTED;
    endcase
    if (cpu.cpu_halt) nxt = HALTED;
  end
  // nin keeps its latched operand across PRESENT and is zero everywhere else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      cpu.nin   <= '0;
      cpu.enter <= 1'b0;
      out_last  <= '0;
      out_count <= '0;
      overflow  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= nxt;
      cpu.enter <= nxt == PRESENT;
      cpu.nin   <= (nxt == PRESENT) ? ((state == PRESENT) ? cpu.nin : mem[rp]) : 8'h00;
      halted    <= nxt == HALTED;
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count     <= count + (AW+1)'(wr) - (AW+1)'(pop);
      overflow  <= overflow | (push && full && !pop);
      if (cpu.cpu_out_strobe) begin
        out_last  <= cpu.cpu_nout;
        out_count <= out_count + {7'd0, out_count != 8'hFF};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= push_data;
  end
endmodule

// File: doc/cpu_io_host.md
CPU_IO_HOST -- requirements
Module: cpu_io_host

Interface
REQ-001 Parameter DEPTH, default 4, sets the input queue depth in entries; SHALL be a power of two and at least 2.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-004 push  input  1  enqueue push_data this cycle.
REQ-005 push_data  input  8  operand value to queue for the CPU.
REQ-006 cpu_in_req  input  1  high while the CPU sits in its input state waiting for enter.
REQ-007 cpu_out_strobe  input  1  one-cycle pulse: cpu_nout holds a new output value.
REQ-008 cpu_nout  input  8  CPU output value.
REQ-009 cpu_halt  input  1  CPU halt indication.
REQ-010 nin  output  8  value presented to the CPU input port.
REQ-011 enter  output  1  input-valid handshake to the CPU.
REQ-012 out_last  output  8  most recent captured CPU output.
REQ-013 out_count  output  8  number of outputs captured, saturating at 255.
REQ-014 count  output  log2(DEPTH)+1  queue occupancy.
REQ-015 empty, full, overflow, halted  output  1 each  queue empty, queue full, sticky dropped-push flag, host stopped.

Function
REQ-016 Queue SHALL be a FIFO of DEPTH 8-bit entries: push when not full writes the tail and increments count.
REQ-017 Push when full SHALL drop the data, leave count unchanged and set overflow; overflow stays set until reset.
REQ-018 Push and pop in the same cycle SHALL both occur and leave count unchanged; push while full SHALL be accepted when a pop occurs that cycle.
REQ-019 Pointers SHALL wrap modulo DEPTH; empty = (count==0), full = (count==DEPTH), both combinational from count.
REQ-020 Handshake FSM states: IDLE, PRESENT, RELEASE, HALTED.
REQ-021 IDLE: enter=0, nin=0; on cpu_in_req=1 and empty=0, latch queue head into the nin register and go to PRESENT the next cycle.
REQ-022 PRESENT: enter=1, nin=latched value held stable; stay in PRESENT while cpu_in_req=1; when cpu_in_req=0, pop the head that cycle and go to RELEASE.
REQ-023 RELEASE: enter=0 for exactly one cycle, then go to IDLE; this ensures enter deasserts between consecutive operands regardless of the CPU clock ratio.
REQ-024 cpu_in_req=1 with an empty queue SHALL keep the FSM in IDLE with enter=0 until data arrives; no timeout.
REQ-025 cpu_halt=1 SHALL force HALTED on the next edge from any state: enter=0, nin=0, halted=1, and no pop.
REQ-026 An operand presented when halt occurs SHALL remain queued.
REQ-027 HALTED is exited only by reset. Pushes SHALL still be accepted while halted.
REQ-028 cpu_out_strobe=1 SHALL load cpu_nout into out_last and increment out_count on the same edge, in any state including HALTED.
REQ-029 out_count SHALL saturate at 255 and not wrap.
REQ-030 Latency: first enter high SHALL be 1 cycle after the cycle where cpu_in_req=1 and empty=0 are sampled in IDLE.
REQ-031 The pop for an operand SHALL take effect on the edge ending the PRESENT cycle that sees cpu_in_req=0.
REQ-032 All outputs except empty and full SHALL be registered.

Reset
REQ-033 reset=0 SHALL asynchronously set: FSM=IDLE, pointers=0, count=0, nin=0, enter=0, out_last=0, out_count=0, overflow=0, halted=0; empty=1, full=0.
REQ-034 Queue storage contents need not be cleared.
REQ-035 Reset asserted mid-handshake (PRESENT) SHALL drop enter immediately and discard all queued operands.

Verification
REQ-036 Push 0x12, then 0x34; assert cpu_in_req -> next cycle enter=1, nin=0x12. Drop cpu_in_req -> count 2->1, one RELEASE cycle with enter=0. Reassert -> nin=0x34.
REQ-037 Push 5 values with DEPTH=4 -> full=1, count=4, overflow=1, fifth value lost. Push+pop in one cycle while full -> count stays 4, new value accepted.
REQ-038 cpu_in_req=1 with queue empty for 10 cycles -> enter=0 throughout. Push 0x7F -> enter=1, nin=0x7F 2 cycles after push.
REQ-039 cpu_halt=1 during PRESENT with 0x55 at head -> next edge halted=1, enter=0, nin=0, count unchanged. cpu_in_req toggles afterwards -> no further enter.
REQ-040 Apply 256 cpu_out_strobe pulses, last with cpu_nout=0xA5 -> out_count=255, out_last=0xA5.
REQ-041 Assert reset=0 between clock edges during PRESENT -> enter and count go to 0 without waiting for a clock edge.
